// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared constants and BTB entry type for the branch predictor
package bp_pkg;

    localparam int XLEN_DEF        = 32;
    localparam int BHT_ENTRIES_DEF = 64;
    localparam int BTB_ENTRIES_DEF = 16;

    localparam int BHT_IDX_W = $clog2(BHT_ENTRIES_DEF);
    localparam int BTB_IDX_W = $clog2(BTB_ENTRIES_DEF);
    localparam int BTB_TAG_W = XLEN_DEF - 2 - BTB_IDX_W;

    // Weakly not-taken: one taken outcome flips the prediction.
    localparam logic [1:0] BHT_RST = 2'b01;

    typedef struct packed {
        logic                 valid;
        logic                 uncond;
        logic [BTB_TAG_W-1:0] tag;
        logic [XLEN_DEF-1:0]  target;
    } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit saturating up/down counter, async reset to weakly not-taken
module sat_counter2
    import bp_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up,
    output logic [1:0] ctr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr <= BHT_RST;
        end else if (en) begin
            if (up && ctr != 2'b11) begin
                ctr <= ctr + 2'd1;
            end else if (!up && ctr != 2'b00) begin
                ctr <= ctr - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BHT/BTB next-PC predictor trained by EX-stage branch resolution
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int BHT_ENTRIES = BHT_ENTRIES_DEF,
    parameter int BTB_ENTRIES = BTB_ENTRIES_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_cond,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred
);

    logic [BHT_ENTRIES-1:0][1:0] bht_ctr;
    btb_entry_t                  btb_q [BTB_ENTRIES];

    logic [BHT_IDX_W-1:0] if_bht_idx, ex_bht_idx;
    logic [BTB_IDX_W-1:0] if_btb_idx, ex_btb_idx;
    logic [BTB_TAG_W-1:0] if_tag, ex_tag;
    btb_entry_t           if_entry;
    logic                 if_hit;
    logic                 bht_train;
    logic                 btb_we;
    logic                 unused_ok;

    assign if_bht_idx = if_pc[2 +: BHT_IDX_W];
    assign if_btb_idx = if_pc[2 +: BTB_IDX_W];
    assign if_tag     = if_pc[XLEN-1 -: BTB_TAG_W];
    assign ex_bht_idx = ex_pc[2 +: BHT_IDX_W];
    assign ex_btb_idx = ex_pc[2 +: BTB_IDX_W];
    assign ex_tag     = ex_pc[XLEN-1 -: BTB_TAG_W];

    // JALR is only counted; its target depends on a register and is not cached.
    assign unused_ok = ^{if_pc[1:0], ex_pc[1:0], ex_is_jalr};

    // Prediction reads registered state only, so a same-cycle write is not visible.
    assign if_entry    = btb_q[if_btb_idx];
    assign if_hit      = if_entry.valid && (if_entry.tag == if_tag);
    assign pred_taken  = if_valid && if_hit && (if_entry.uncond || bht_ctr[if_bht_idx][1]);
    assign pred_target = pred_taken ? if_entry.target : if_pc + XLEN'(4);

    assign mispredict  = ex_valid && ((ex_taken != ex_pred_taken) ||
                                      (ex_taken && (ex_target != ex_pred_target)));
    assign redirect_pc = ex_taken ? ex_target : ex_pc + XLEN'(4);

    assign bht_train = ex_valid && ex_is_cond;
    assign btb_we    = ex_valid && ((ex_is_cond && ex_taken) || ex_is_jal);

    for (genvar i = 0; i < BHT_ENTRIES; i++) begin : g_bht
        sat_counter2 u_ctr (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (bht_train && (ex_bht_idx == BHT_IDX_W'(i))),
            .up    (ex_taken),
            .ctr   (bht_ctr[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_q[i] <= '0;
            end
        end else if (btb_we) begin
            btb_q[ex_btb_idx] <= '{valid: 1'b1, uncond: ex_is_jal, tag: ex_tag, target: ex_target};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else if (ex_valid) begin
            if (stat_branches != 32'hFFFF_FFFF) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mispredict && stat_mispred != 32'hFFFF_FFFF) begin
                stat_mispred <= stat_mispred + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_cond, ex_is_jal, ex_is_jalr;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches, stat_mispred;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_is_cond     (ex_is_cond),
        .ex_is_jal      (ex_is_jal),
        .ex_is_jalr     (ex_is_jalr),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .stat_branches  (stat_branches),
        .stat_mispred   (stat_mispred)
    );

    // kind: 0 cond, 1 jal, 2 jalr
    task automatic drive_ex(input logic [31:0] pc, input int kind, input logic taken,
                            input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt);
        ex_valid       = 1'b1;
        ex_pc          = pc;
        ex_is_cond     = (kind == 0);
        ex_is_jal      = (kind == 1);
        ex_is_jalr     = (kind == 2);
        ex_taken       = taken;
        ex_target      = tgt;
        ex_pred_taken  = ptaken;
        ex_pred_target = ptgt;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_valid = 1'b1; if_pc = 32'h100; ex_valid = 1'b0;
        ex_pc = '0; ex_is_cond = 0; ex_is_jal = 0; ex_is_jalr = 0; ex_taken = 0;
        ex_target = '0; ex_pred_taken = 0; ex_pred_target = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_pred_taken got %0b want 0", pred_taken); end
        n_vec++; if (pred_target !== 32'h104) begin n_err++; $display("FAIL reset_pred_target got %h want 00000104", pred_target); end
        n_vec++; if (stat_branches !== 0 || stat_mispred !== 0) begin n_err++; $display("FAIL reset_stats got %0d/%0d want 0/0", stat_branches, stat_mispred); end
        n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL reset_mispredict got %0b want 0", mispredict); end
    endtask

    task automatic test_train_loop();
        drive_ex(32'h200, 0, 1'b1, 32'h1F0, 1'b0, 32'h204);
        n_vec++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL loop_first_mispredict got %0b want 1", mispredict); end
        n_vec++; if (redirect_pc !== 32'h1F0) begin n_err++; $display("FAIL loop_first_redirect got %h want 000001f0", redirect_pc); end
        step();
        drive_ex(32'h200, 0, 1'b1, 32'h1F0, 1'b1, 32'h1F0);
        n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL loop_second_mispredict got %0b want 0", mispredict); end
        step();
        if_pc = 32'h200; #1;
        n_vec++; if (pred_taken !== 1'b1 || pred_target !== 32'h1F0) begin n_err++; $display("FAIL loop_predict got %0b/%h want 1/000001f0", pred_taken, pred_target); end
        if_valid = 1'b0; #1;
        n_vec++; if (pred_taken !== 1'b0 || pred_target !== 32'h204) begin n_err++; $display("FAIL if_invalid got %0b/%h want 0/00000204", pred_taken, pred_target); end
        if_valid = 1'b1;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) begin
            drive_ex(32'h200, 0, 1'b1, 32'h1F0, 1'b1, 32'h1F0);
            step();
        end
        drive_ex(32'h200, 0, 1'b0, 32'h0, 1'b1, 32'h1F0);
        step();
        if_pc = 32'h200; #1;
        n_vec++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL sat_one_nt got %0b want 1", pred_taken); end
        drive_ex(32'h200, 0, 1'b0, 32'h0, 1'b1, 32'h1F0);
        step();
        n_vec++; if (pred_taken !== 1'b0 || pred_target !== 32'h204) begin n_err++; $display("FAIL sat_two_nt got %0b/%h want 0/00000204", pred_taken, pred_target); end
        for (int i = 0; i < 3; i++) begin
            drive_ex(32'h200, 0, 1'b0, 32'h0, 1'b0, 32'h204);
            step();
        end
        drive_ex(32'h200, 0, 1'b1, 32'h1F0, 1'b0, 32'h204);
        step();
        n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL sat_floor got %0b want 0", pred_taken); end
        n_vec++; if (stat_branches !== 32'd12 || stat_mispred !== 32'd4) begin n_err++; $display("FAIL sat_stats got %0d/%0d want 12/4", stat_branches, stat_mispred); end
    endtask

    task automatic test_jal_jalr();
        // 0x200 and 0x300 alias in both tables; drive the shared counter to 00 first.
        drive_ex(32'h200, 0, 1'b0, 32'h0, 1'b0, 32'h204);
        step();
        drive_ex(32'h300, 1, 1'b1, 32'h400, 1'b0, 32'h304);
        n_vec++; if (mispredict !== 1'b1 || redirect_pc !== 32'h400) begin n_err++; $display("FAIL jal_mispredict got %0b/%h want 1/00000400", mispredict, redirect_pc); end
        step();
        if_pc = 32'h300; #1;
        n_vec++; if (pred_taken !== 1'b1 || pred_target !== 32'h400) begin n_err++; $display("FAIL jal_predict got %0b/%h want 1/00000400", pred_taken, pred_target); end
        if_pc = 32'h200; #1;
        n_vec++; if (pred_taken !== 1'b0 || pred_target !== 32'h204) begin n_err++; $display("FAIL btb_overwrite got %0b/%h want 0/00000204", pred_taken, pred_target); end
        for (int i = 0; i < 2; i++) begin
            drive_ex(32'h500, 2, 1'b1, 32'h600, 1'b0, 32'h504);
            n_vec++; if (mispredict !== 1'b1 || redirect_pc !== 32'h600) begin n_err++; $display("FAIL jalr_mispredict_%0d got %0b/%h want 1/00000600", i, mispredict, redirect_pc); end
            step();
            if_pc = 32'h500; #1;
            n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL jalr_predict_%0d got %0b want 0", i, pred_taken); end
        end
    endtask

    task automatic test_target_mismatch();
        drive_ex(32'h640, 0, 1'b1, 32'h800, 1'b1, 32'h700);
        n_vec++; if (mispredict !== 1'b1 || redirect_pc !== 32'h800) begin n_err++; $display("FAIL target_mismatch got %0b/%h want 1/00000800", mispredict, redirect_pc); end
        ex_taken = 1'b0; ex_pred_taken = 1'b0; #1;
        n_vec++; if (mispredict !== 1'b0 || redirect_pc !== 32'h644) begin n_err++; $display("FAIL nt_correct got %0b/%h want 0/00000644", mispredict, redirect_pc); end
        ex_valid = 1'b0; ex_taken = 1'b1; #1;
        n_vec++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL ex_invalid got %0b want 0", mispredict); end
        step();
    endtask

    task automatic test_back_to_back_and_async_reset();
        if_pc = 32'h300;
        drive_ex(32'h900, 1, 1'b1, 32'hA00, 1'b0, 32'h904);
        #2;
        n_vec++; if (pred_taken !== 1'b1 || pred_target !== 32'h400) begin n_err++; $display("FAIL same_cycle_old got %0b/%h want 1/00000400", pred_taken, pred_target); end
        step();
        if_pc = 32'h900; #1;
        n_vec++; if (pred_taken !== 1'b1 || pred_target !== 32'hA00) begin n_err++; $display("FAIL same_cycle_new got %0b/%h want 1/00000a00", pred_taken, pred_target); end
        drive_ex(32'h900, 0, 1'b1, 32'hB00, 1'b1, 32'hA00);
        rst_n = 1'b0; #1;
        n_vec++; if (pred_taken !== 1'b0 || pred_target !== 32'h904) begin n_err++; $display("FAIL async_reset_pred got %0b/%h want 0/00000904", pred_taken, pred_target); end
        n_vec++; if (stat_branches !== 0 || stat_mispred !== 0) begin n_err++; $display("FAIL async_reset_stats got %0d/%0d want 0/0", stat_branches, stat_mispred); end
        @(posedge clk); #1;
        ex_valid = 1'b0;
        rst_n = 1'b1; #1;
        n_vec++; if (pred_taken !== 1'b0 || stat_branches !== 0) begin n_err++; $display("FAIL reset_discard got %0b/%0d want 0/0", pred_taken, stat_branches); end
        drive_ex(32'h900, 0, 1'b1, 32'hB00, 1'b0, 32'h904);
        step();
        n_vec++; if (pred_taken !== 1'b1 || pred_target !== 32'hB00) begin n_err++; $display("FAIL post_reset_ctr got %0b/%h want 1/00000b00", pred_taken, pred_target); end
    endtask

    initial begin
        test_reset();
        test_train_loop();
        test_saturation();
        test_jal_jalr();
        test_target_mismatch();
        test_back_to_back_and_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
